// File: rtl/uart_tx_controller.sv
// Drains SRAM addresses 0..LAST_ADDR over a UART line, one 8N1 frame per byte.
// A one-cycle start pulse begins the drain; done pulses once after the final stop bit.
module uart_tx_controller #(
  parameter int unsigned CLK_PER_BIT = 87,
  parameter int unsigned LAST_ADDR   = 1001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        sram_ready_i,
  input  logic [15:0] sram_rdata_i,
  output logic [15:0] sram_addr_o,
  output logic        sram_start_o,
  output logic        sram_rw_o,
  output logic        uart_out_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    START_BIT,
    DATA_BITS,
    STOP_BIT,
    NEXT
  } state_e;

  localparam logic [15:0] BAUD_LAST = 16'(CLK_PER_BIT - 1);
  localparam logic [15:0] ADDR_LAST = 16'(LAST_ADDR);

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic        sramStart_q, sramStart_d;
  logic        uart_q, uart_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  shift_q, shift_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bitIdx_q, bitIdx_d;
  logic        baudEnd;
  logic        unusedRdataHi;

  assign baudEnd       = (baud_q == BAUD_LAST);
  assign unusedRdataHi = ^sram_rdata_i[15:8];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      sramStart_q <= 1'b1;
      uart_q      <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      shift_q     <= '0;
      baud_q      <= '0;
      bitIdx_q    <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      sramStart_q <= sramStart_d;
      uart_q      <= uart_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      shift_q     <= shift_d;
      baud_q      <= baud_d;
      bitIdx_q    <= bitIdx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    sramStart_d = sramStart_q;
    uart_d      = uart_q;
    busy_d      = busy_q;
    done_d      = done_q;
    shift_d     = shift_q;
    baud_d      = baud_q;
    bitIdx_d    = bitIdx_q;

    unique case (state_q)
      IDLE: begin
        done_d = 1'b0;
        // A start coinciding with the done pulse belongs to the finishing drain and is dropped.
        if (start_i && !done_q) begin
          sramStart_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = REQ;
        end
      end

      REQ: begin
        sramStart_d = 1'b1;
        state_d     = WAIT;
      end

      WAIT: begin
        if (sram_ready_i) begin
          shift_d = sram_rdata_i[7:0];
          uart_d  = 1'b0;
          baud_d  = '0;
          state_d = START_BIT;
        end
      end

      START_BIT: begin
        if (baudEnd) begin
          uart_d   = shift_q[0];
          shift_d  = {1'b0, shift_q[7:1]};
          bitIdx_d = '0;
          baud_d   = '0;
          state_d  = DATA_BITS;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end

      DATA_BITS: begin
        if (baudEnd) begin
          baud_d = '0;
          if (bitIdx_q == 3'd7) begin
            uart_d  = 1'b1;
            state_d = STOP_BIT;
          end else begin
            uart_d   = shift_q[0];
            shift_d  = {1'b0, shift_q[7:1]};
            bitIdx_d = bitIdx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end

      STOP_BIT: begin
        if (baudEnd) begin
          baud_d  = '0;
          state_d = NEXT;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end

      NEXT: begin
        if (addr_q == ADDR_LAST) begin
          addr_d  = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          addr_d      = addr_q + 16'd1;
          sramStart_d = 1'b0;
          state_d     = REQ;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign sram_addr_o  = addr_q;
  assign sram_start_o = sramStart_q;
  assign sram_rw_o    = 1'b1;
  assign uart_out_o   = uart_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule
